// File: rtl/vga_sync_monitor.sv
// VGA sync monitor: locks onto hSync/vSync timing and
// flags sticky horizontal/vertical timing errors.
module vga_sync_monitor #(
    parameter int H_TOTAL_CLK     = 3200,
    parameter int H_PULSE_CLK     = 384,
    parameter int V_TOTAL_LINES   = 525,
    parameter int V_PULSE_LINES   = 2,
    parameter int TOL             = 4,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic        ClkPort,
    input  logic        Reset,
    input  logic        hSync,
    input  logic        vSync,
    input  logic        err_clr,
    output logic        locked,
    output logic        h_err,
    output logic        v_err,
    output logic [15:0] frame_count,
    output logic [12:0] last_h_period,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        H_ALIGN = 2'd1,
        V_ALIGN = 2'd2,
        LOCKED  = 2'd3
    } state_e;

    localparam logic       INACT = (SYNC_ACTIVE_LOW != 0);
    localparam logic [12:0] H_MAX = 13'h1FFF;
    localparam logic [12:0] H_TMO = 13'(2 * H_TOTAL_CLK);
    localparam logic [9:0]  V_TOT = 10'(V_TOTAL_LINES);
    localparam logic [9:0]  V_PLS = 10'(V_PULSE_LINES);
    localparam logic [9:0]  V_MAX = 10'h3FF;

    logic [2:0]  hs_q;
    logic [2:0]  vs_q;
    logic [12:0] h_cnt_q;
    logic [12:0] h_cnt_d;
    logic [9:0]  v_lines_q;
    logic [2:0]  good_lines_q;
    logic [2:0]  good_lines_d;
    state_e      state_q;
    state_e      state_d;
    logic        locked_q;
    logic        h_err_q;
    logic        v_err_q;
    logic [15:0] frame_count_q;
    logic [12:0] last_h_period_q;

    logic h_act, h_hist, v_act, v_hist;
    logic h_lead, h_trail, v_lead, v_trail;
    logic per_ok, wid_ok, h_bad, h_tmo;
    logic v_len_bad, v_pw_bad;
    logic in_lock, h_set, v_set, frame_ok;

    function automatic logic in_tol(input logic [12:0] val,
                                    input int tgt);
        int diff;
        diff = int'(val) - tgt;
        return (diff <= TOL) && (diff >= -TOL);
    endfunction

    // Two synchronizer stages plus one history stage per sync input
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            hs_q <= {3{INACT}};
            vs_q <= {3{INACT}};
        end else begin
            hs_q <= {hs_q[1:0], hSync};
            vs_q <= {vs_q[1:0], vSync};
        end
    end

    assign h_act   = hs_q[1] ^ INACT;
    assign h_hist  = hs_q[2] ^ INACT;
    assign v_act   = vs_q[1] ^ INACT;
    assign v_hist  = vs_q[2] ^ INACT;
    assign h_lead  = h_act & ~h_hist;
    assign h_trail = ~h_act & h_hist;
    assign v_lead  = v_act & ~v_hist;
    assign v_trail = ~v_act & v_hist;

    // Event qualification and next-state decode
    always_comb begin
        per_ok    = in_tol(h_cnt_q, H_TOTAL_CLK);
        wid_ok    = in_tol(h_cnt_q, H_PULSE_CLK);
        h_bad     = (h_lead & ~per_ok) | (h_trail & ~wid_ok);
        h_tmo     = ~h_lead & (h_cnt_q >= H_TMO);
        v_len_bad = v_lead & (v_lines_q != V_TOT);
        v_pw_bad  = v_trail & (v_lines_q != V_PLS);
        in_lock   = (state_q == LOCKED);
        h_set     = in_lock & (h_bad | h_tmo);
        v_set     = in_lock & (v_len_bad | v_pw_bad);
        frame_ok  = in_lock & v_lead & ~v_len_bad & ~h_set;
        h_cnt_d   = h_lead ? 13'd1 :
                    (h_cnt_q == H_MAX) ? H_MAX : h_cnt_q + 13'd1;
        state_d      = state_q;
        good_lines_d = good_lines_q;
        unique case (state_q)
            SEARCH: begin
                if (h_lead) begin
                    state_d      = H_ALIGN;
                    good_lines_d = 3'd0;
                end
            end
            H_ALIGN: begin
                if (h_bad | h_tmo) begin
                    state_d = SEARCH;
                end else if (h_lead) begin
                    good_lines_d = good_lines_q + 3'd1;
                    if (good_lines_q == 3'd3) state_d = V_ALIGN;
                end
            end
            V_ALIGN: begin
                if (h_bad | h_tmo) state_d = SEARCH;
                else if (v_lead)   state_d = LOCKED;
            end
            LOCKED: begin
                if (h_set | v_set) state_d = SEARCH;
            end
        endcase
    end

    // Free-running line timer, restarted at each hSync leading edge
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) h_cnt_q <= 13'd0;
        else       h_cnt_q <= h_cnt_d;
    end

    // Lines since last vSync leading edge; coincident hSync counts in
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            v_lines_q <= 10'd0;
        end else if (v_lead) begin
            v_lines_q <= h_lead ? 10'd1 : 10'd0;
        end else if (h_lead && v_lines_q != V_MAX) begin
            v_lines_q <= v_lines_q + 10'd1;
        end
    end

    // Lock FSM with registered status, sticky errors and frame counter
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            state_q         <= SEARCH;
            good_lines_q    <= 3'd0;
            locked_q        <= 1'b0;
            h_err_q         <= 1'b0;
            v_err_q         <= 1'b0;
            frame_count_q   <= 16'd0;
            last_h_period_q <= 13'd0;
        end else begin
            state_q      <= state_d;
            good_lines_q <= good_lines_d;
            locked_q     <= (state_d == LOCKED);
            if (h_set)        h_err_q <= 1'b1;
            else if (err_clr) h_err_q <= 1'b0;
            if (v_set)        v_err_q <= 1'b1;
            else if (err_clr) v_err_q <= 1'b0;
            if (frame_ok) frame_count_q <= frame_count_q + 16'd1;
            if (h_lead && state_q != SEARCH) last_h_period_q <= h_cnt_q;
        end
    end

    assign locked        = locked_q;
    assign h_err         = h_err_q;
    assign v_err         = v_err_q;
    assign frame_count   = frame_count_q;
    assign last_h_period = last_h_period_q;
    assign state         = state_q;

endmodule

// File: doc/vga_sync_monitor.md
VGA_SYNC_MONITOR -- requirements
Module: vga_sync_monitor

Interface
REQ-001 SHALL have parameter H_TOTAL_CLK, default 3200, meaning expected hSync period in ClkPort cycles (800 px x 4).
REQ-002 SHALL have parameter H_PULSE_CLK, default 384, meaning expected hSync active width in ClkPort cycles.
REQ-003 SHALL have parameter V_TOTAL_LINES, default 525, meaning expected hSync leading edges per frame.
REQ-004 SHALL have parameter V_PULSE_LINES, default 2, meaning expected vSync active width in lines.
REQ-005 SHALL have parameter TOL, default 4, meaning +/- cycle tolerance on H period and H pulse checks.
REQ-006 SHALL have parameter SYNC_ACTIVE_LOW, default 1, meaning sync active level is 0 when 1.
REQ-007 SHALL have ports: ClkPort input 1 (100 MHz clock); Reset input 1 (asynchronous, active-high).
REQ-008 SHALL have ports: hSync input 1, vSync input 1 (sync under test); err_clr input 1 (clears sticky errors).
REQ-009 SHALL have ports: locked output 1; h_err output 1; v_err output 1 (sticky flags).
REQ-010 SHALL have ports: frame_count output 16 (good frames); last_h_period output 13 (last measured period); state output 2.

Function
REQ-011 SHALL pass hSync and vSync through a 2-flop synchronizer plus one history flop; leading edge = change to active level, trailing edge = change to inactive level; detection latency 3 ClkPort cycles from the input transition.
REQ-012 SHALL maintain 13-bit h_cnt: loaded with 1 on a leading-edge cycle, else incremented, saturating at 8191.
REQ-013 SHALL take measured period = h_cnt value before load at a hSync leading edge, and store it in last_h_period every leading edge in any state except SEARCH.
REQ-014 SHALL take measured pulse width = h_cnt value at the hSync trailing edge; a line is good iff |period-H_TOTAL_CLK|<=TOL and |width-H_PULSE_CLK|<=TOL.
REQ-015 SHALL implement states SEARCH=0, H_ALIGN=1, V_ALIGN=2, LOCKED=3, driven on state output.
REQ-016 SEARCH: on hSync leading edge -> H_ALIGN, good_lines cleared.
REQ-017 H_ALIGN: each good line increments good_lines; on reaching 4 -> V_ALIGN; any bad period/width -> SEARCH.
REQ-018 V_ALIGN: bad line -> SEARCH; vSync leading edge -> LOCKED, line counter v_lines initialised per REQ-020.
REQ-019 LOCKED: bad period or width -> h_err set, -> SEARCH; h_cnt reaching 2*H_TOTAL_CLK without leading edge -> h_err set, -> SEARCH (in H_ALIGN/V_ALIGN timeout -> SEARCH, no flag).
REQ-020 SHALL count hSync leading edges in 10-bit v_lines; at a vSync edge, comparison uses the pre-edge count, then a coincident hSync leading edge counts into the new interval (v_lines=1, else 0 on vSync leading edge).
REQ-021 LOCKED, vSync leading edge: v_lines==V_TOTAL_LINES -> frame_count+1 (wraps 65535->0); else v_err set, -> SEARCH, frame_count unchanged.
REQ-022 LOCKED, vSync trailing edge: v_lines!=V_PULSE_LINES -> v_err set, -> SEARCH.
REQ-023 locked SHALL equal (state==LOCKED), registered, no extra delay.
REQ-024 h_err/v_err SHALL clear on err_clr high at a clock edge; if set and err_clr coincide, set wins.
REQ-025 frame_count SHALL NOT clear on loss of lock, only on Reset.

Reset
REQ-026 Reset high SHALL asynchronously force state=SEARCH, locked=0, h_err=0, v_err=0, frame_count=0, last_h_period=0, h_cnt=0, v_lines=0, good_lines=0, synchronizer flops to inactive level.
REQ-027 Reset asserted mid-frame SHALL abort lock immediately; after release, relock requires full SEARCH->LOCKED sequence.

Verification
REQ-028 Nominal 640x480 timing (3200/384, 525/2 lines) from Reset release -> locked=1 after first vSync leading edge following 4 good lines; frame_count=3 after 3 further frames; no errors.
REQ-029 One line with period 3210 while LOCKED -> h_err=1, state=0, last_h_period=3210; relock after next valid sequence; h_err stays 1 until err_clr.
REQ-030 Frame of 524 lines while LOCKED -> v_err=1, locked=0, frame_count unchanged.
REQ-031 hSync held inactive 6400+ cycles while LOCKED -> h_err=1, state=0; period 3204 and width 380 accepted without error.
REQ-032 err_clr pulsed in same cycle as new h error -> h_err=1; err_clr alone -> h_err=0 next cycle.
REQ-033 frame_count preloaded to 65535 by running 65535 good frames (or forced) -> next good frame gives 0; Reset mid-frame -> all outputs 0 asynchronously.
